camera_frame_writer: RTL and testbench

//  Consumer end of the camera pixel queue. Pops 17-bit queue words: bit16=1 is the frame-start marker, bit16=0 is an RGB565 pixel in [15:0].

---
 rtl/camera_frame_writer_pkg.sv | 24 ++
 rtl/camera_frame_writer_if.sv | 23 ++
 rtl/camera_frame_writer_burst_buffer.sv | 27 ++
 rtl/camera_frame_writer.sv | 166 ++++++++++++++++
 tb/tb_camera_frame_writer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_frame_writer_pkg.sv
// Shared definitions for the camera frame writer: queue word layout, writer
// state encoding and frame geometry helper.
package camera_frame_writer_pkg;

    localparam int QUEUE_WORD_W     = 17;
    localparam int QUEUE_MARKER_BIT = 16;
    localparam int PIXEL_W          = 16;

    typedef enum logic [1:0] {
        WAIT_MARKER,
        FILL,
        REQUEST,
        STREAM
    } state_t;

    function automatic int frame_words(input int width, input int height);
        return width * height;
    endfunction

    function automatic logic [PIXEL_W-1:0] pixel_of(input logic [QUEUE_WORD_W-1:0] word);
        return word[PIXEL_W-1:0];
    endfunction

endpackage

// File: rtl/camera_frame_writer_if.sv
// Burst write command/data handshake between the frame writer (master) and
// the PSRAM controller (slave).
interface camera_frame_writer_if
    import camera_frame_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 21
);
    logic                  mem_cmd_valid;
    logic                  mem_cmd_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_data_req;
    logic [PIXEL_W-1:0]    mem_data;

    modport master (
        output mem_cmd_valid, mem_addr, mem_data,
        input  mem_cmd_ready, mem_data_req
    );

    modport slave (
        input  mem_cmd_valid, mem_addr, mem_data,
        output mem_cmd_ready, mem_data_req
    );
endinterface

// File: rtl/camera_frame_writer_burst_buffer.sv
// One-burst staging store: single write port, registered read port.
// The array carries no reset so it can map onto LUT-RAM.
module burst_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             MemoryClk,
    input  logic             nRST,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge MemoryClk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge MemoryClk) begin
        if (!nRST)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/camera_frame_writer.sv
// Pops pixel-queue words, packs them into bursts and writes them to a
// double-buffered frame store through the memory controller handshake.
module camera_frame_writer
    import camera_frame_writer_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int BURST_LEN    = 16,
    parameter int ADDR_WIDTH   = 21,
    parameter int FRAME_BASE   = 0
) (
    input  logic                     MemoryClk,
    input  logic                     nRST,
    input  logic                     queue_empty,
    input  logic [QUEUE_WORD_W-1:0]  queue_data,
    output logic                     queue_rd_en,
    camera_frame_writer_if.master    mem,
    output logic                     frame_done,
    output logic                     frame_error,
    output logic                     active_frame
);
    localparam int FRAME_WORDS = frame_words(FRAME_WIDTH, FRAME_HEIGHT);
    localparam int IDX_W       = $clog2(FRAME_WORDS + 1);
    localparam int FILL_W      = $clog2(BURST_LEN + 1);
    localparam int BUF_AW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam longint BUF1_END = longint'(FRAME_BASE) + 2 * longint'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE0 = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(FRAME_BASE + FRAME_WORDS);

    if (FRAME_WORDS % BURST_LEN != 0) begin : g_chk_burst
        $error("frame size is not a whole number of bursts");
    end
    if (BUF1_END > (longint'(1) << ADDR_WIDTH)) begin : g_chk_addr
        $error("frame buffer 1 does not fit in the address space");
    end

    state_t                  state, state_next;
    logic [IDX_W-1:0]        index;
    logic [IDX_W:0]          index_adv;
    logic [FILL_W-1:0]       fill, rd_k;
    logic                    write_buf, rd_valid;
    logic                    rd_marker, rd_pixel, at_origin;
    logic                    mid_marker, fill_last, burst_last, frame_end;
    logic                    buf_we, buf_re;
    logic                    cmd_valid;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [PIXEL_W-1:0]      rd_word;

    assign rd_marker = rd_valid &&  queue_data[QUEUE_MARKER_BIT];
    assign rd_pixel  = rd_valid && !queue_data[QUEUE_MARKER_BIT];
    assign at_origin = (index == '0) && (fill == '0);
    assign index_adv = {1'b0, index} + (IDX_W+1)'(BURST_LEN);

    always_ff @(posedge MemoryClk) begin
        if (!nRST) state <= WAIT_MARKER;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_MARKER: if (rd_marker)          state_next = FILL;
            FILL:        if (fill_last)          state_next = REQUEST;
            REQUEST:     if (mem.mem_cmd_ready)  state_next = STREAM;
            STREAM:      if (burst_last)         state_next = frame_end ? WAIT_MARKER : FILL;
            default:                             state_next = WAIT_MARKER;
        endcase
    end

    // Pops are gated by nRST so every output reads zero while reset is held.
    always_comb begin
        queue_rd_en = nRST && !queue_empty
                   && (state == WAIT_MARKER || state == FILL)
                   && (({1'b0, fill} + (FILL_W+1)'(rd_valid)) < (FILL_W+1)'(BURST_LEN));
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        buf_we     = 1'b0;
        buf_re     = 1'b0;
        mid_marker = 1'b0;
        fill_last  = 1'b0;
        burst_last = 1'b0;
        frame_end  = 1'b0;
        case (state)
            FILL: begin
                buf_we     = rd_pixel;
                fill_last  = rd_pixel && (fill == FILL_W'(BURST_LEN - 1));
                mid_marker = rd_marker && !at_origin;
            end
            REQUEST: begin
                cmd_valid = 1'b1;
                cmd_addr  = (write_buf ? BASE1 : BASE0) + ADDR_WIDTH'(index);
            end
            STREAM: begin
                buf_re     = mem.mem_data_req;
                burst_last = buf_re && (rd_k == FILL_W'(BURST_LEN - 1));
                frame_end  = burst_last && (index_adv == (IDX_W+1)'(FRAME_WORDS));
            end
            default: ;
        endcase
    end

    always_ff @(posedge MemoryClk) begin
        if (!nRST) begin
            index        <= '0;
            fill         <= '0;
            rd_k         <= '0;
            write_buf    <= 1'b1;
            active_frame <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            rd_valid    <= queue_rd_en;
            frame_done  <= frame_end;
            frame_error <= mid_marker;
            case (state)
                WAIT_MARKER: if (rd_marker) begin
                    index <= '0;
                    fill  <= '0;
                end
                FILL: begin
                    if (mid_marker) begin
                        index <= '0;
                        fill  <= '0;
                    end else if (rd_pixel) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
                REQUEST: rd_k <= '0;
                STREAM: if (buf_re) begin
                    rd_k <= rd_k + FILL_W'(1);
                    if (burst_last) begin
                        // fill is cleared on both exits so WAIT_MARKER can pop again
                        fill <= '0;
                        if (frame_end) begin
                            index        <= '0;
                            active_frame <= write_buf;
                            write_buf    <= ~write_buf;
                        end else begin
                            index <= index_adv[IDX_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    burst_buffer #(
        .DEPTH (BURST_LEN),
        .WIDTH (PIXEL_W)
    ) u_burst_buffer (
        .MemoryClk (MemoryClk),
        .nRST      (nRST),
        .we        (buf_we),
        .waddr     (fill[BUF_AW-1:0]),
        .wdata     (pixel_of(queue_data)),
        .re        (buf_re),
        .raddr     (rd_k[BUF_AW-1:0]),
        .rdata     (rd_word)
    );

    assign mem.mem_cmd_valid = cmd_valid;
    assign mem.mem_addr      = cmd_addr;
    assign mem.mem_data      = rd_word;
endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer with a pixel-queue model and a
// burst-accepting memory controller model.
module tb_camera_frame_writer;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int BL = 4;
    localparam int AW = 21;

    logic        MemoryClk = 1'b0;
    logic        nRST = 1'b0;
    logic        queue_empty;
    logic [16:0] queue_data = '0;
    logic        queue_rd_en;
    logic        frame_done, frame_error, active_frame;

    camera_frame_writer_if #(.ADDR_WIDTH(AW)) mif ();

    camera_frame_writer #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .BURST_LEN    (BL),
        .ADDR_WIDTH   (AW),
        .FRAME_BASE   (0)
    ) u_dut (
        .MemoryClk    (MemoryClk),
        .nRST         (nRST),
        .queue_empty  (queue_empty),
        .queue_data   (queue_data),
        .queue_rd_en  (queue_rd_en),
        .mem          (mif),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .active_frame (active_frame)
    );

    always #5 MemoryClk = ~MemoryClk;

    // pixel queue: data appears the cycle after the pop
    logic [16:0] qmem [512];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int overpop = 0;
    assign queue_empty = (rd_ptr == wr_ptr);

    always @(posedge MemoryClk) begin
        if (queue_rd_en) begin
            if (rd_ptr == wr_ptr) overpop <= overpop + 1;
            else begin
                queue_data <= qmem[rd_ptr];
                rd_ptr     <= rd_ptr + 1;
            end
        end
    end

    // controller: after accepting a command, pulls BL words on consecutive cycles
    int   req_cnt = 0;
    logic req_taken = 1'b0;
    assign mif.mem_data_req = (req_cnt != 0);

    always @(posedge MemoryClk) begin
        if (!nRST) begin
            req_cnt   <= 0;
            req_taken <= 1'b0;
        end else begin
            req_taken <= mif.mem_data_req;
            if (mif.mem_cmd_valid && mif.mem_cmd_ready) req_cnt <= BL;
            else if (req_cnt != 0)                      req_cnt <= req_cnt - 1;
        end
    end

    logic [31:0] cmd_log  [64];
    logic [15:0] data_log [512];
    int ncmd = 0, ndata = 0, ndone = 0, nerr = 0;

    always @(negedge MemoryClk) begin
        if (mif.mem_cmd_valid && mif.mem_cmd_ready && ncmd < 64) begin
            cmd_log[ncmd] = 32'(mif.mem_addr);
            ncmd++;
        end
        if (req_taken && ndata < 512) begin
            data_log[ndata] = mif.mem_data;
            ndata++;
        end
        if (frame_done)  ndone++;
        if (frame_error) nerr++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MemoryClk);
            #1;
        end
    endtask

    task automatic push(input logic [16:0] w);
        qmem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic push_frame(input logic [15:0] first);
        push(17'h10000);
        for (int i = 0; i < W*H; i++) push({1'b0, first + 16'(i)});
    endtask

    task automatic wait_data(input int target, input string tag);
        int t = 0;
        while (ndata < target && t < 1000) begin
            @(negedge MemoryClk);
            t++;
        end
        check(tag, 32'(ndata >= target), 32'd1);
        tick(3);
    endtask

    task automatic check_frame(input string tag, input int cb, input int db,
                               input int addr0, input logic [15:0] first);
        for (int b = 0; b < (W*H)/BL; b++)
            check($sformatf("%s_addr%0d", tag, b), cmd_log[cb+b], 32'(addr0 + BL*b));
        for (int i = 0; i < W*H; i++)
            check($sformatf("%s_data%0d", tag, i), 32'(data_log[db+i]), 32'(first + 16'(i)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},  32'(queue_rd_en),       32'd0);
        check({tag, "_valid"},  32'(mif.mem_cmd_valid), 32'd0);
        check({tag, "_addr"},   32'(mif.mem_addr),      32'd0);
        check({tag, "_data"},   32'(mif.mem_data),      32'd0);
        check({tag, "_done"},   32'(frame_done),        32'd0);
        check({tag, "_err"},    32'(frame_error),       32'd0);
        check({tag, "_active"}, 32'(active_frame),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int cb, db, rp0, t, done0, err0;

        mif.mem_cmd_ready = 1'b1;
        nRST = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        nRST = 1'b1;
        tick(2);

        // frame 1: junk before the marker is dropped, lands in buffer 1
        for (int i = 0; i < 5; i++) push(17'h00AA0 + 17'(i));
        cb = ncmd; db = ndata;
        push_frame(16'h0001);
        wait_data(db + 16, "f1_wait");
        check_frame("f1", cb, db, 16, 16'h0001);
        check("f1_ncmd", 32'(ncmd), 32'(cb + 4));
        check("f1_done", 32'(ndone), 32'd1);
        check("f1_active", 32'(active_frame), 32'd1);
        check("f1_err", 32'(nerr), 32'd0);

        // frame 2 -> buffer 0
        cb = ncmd; db = ndata;
        push_frame(16'h0001);
        wait_data(db + 16, "f2_wait");
        check_frame("f2", cb, db, 0, 16'h0001);
        check("f2_done", 32'(ndone), 32'd2);
        check("f2_active", 32'(active_frame), 32'd0);

        // frame 3 -> buffer 1 again
        cb = ncmd; db = ndata;
        push_frame(16'h0021);
        wait_data(db + 16, "f3_wait");
        check_frame("f3", cb, db, 16, 16'h0021);
        check("f3_done", 32'(ndone), 32'd3);
        check("f3_active", 32'(active_frame), 32'd1);

        // reset while streaming: outputs clear, next frame goes to buffer 1
        db = ndata;
        push_frame(16'h0301);
        t = 0;
        while (ndata < db + 2 && t < 500) begin
            @(negedge MemoryClk);
            t++;
        end
        check("rst_mid_reached", 32'(ndata >= db + 2), 32'd1);
        @(posedge MemoryClk); #1;
        nRST = 1'b0;
        @(posedge MemoryClk); #1;
        check_idle_outputs("rst_mid");
        nRST = 1'b1;
        tick(2);
        cb = ncmd; db = ndata;
        push_frame(16'h0401);
        wait_data(db + 16, "f6_wait");
        check_frame("f6", cb, db, 16, 16'h0401);
        check("f6_done", 32'(ndone), 32'd4);
        check("f6_active", 32'(active_frame), 32'd1);

        // controller stalls: command held, no pops
        mif.mem_cmd_ready = 1'b0;
        rp0 = rd_ptr;
        cb = ncmd; db = ndata;
        push_frame(16'h0201);
        t = 0;
        while (!mif.mem_cmd_valid && t < 200) begin
            @(negedge MemoryClk);
            t++;
        end
        check("stall_valid_seen", 32'(mif.mem_cmd_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge MemoryClk);
            check($sformatf("stall_valid%0d", i), 32'(mif.mem_cmd_valid), 32'd1);
            check($sformatf("stall_addr%0d", i),  32'(mif.mem_addr),      32'd0);
            check($sformatf("stall_rd_en%0d", i), 32'(queue_rd_en),       32'd0);
        end
        check("stall_popped", 32'(rd_ptr - rp0), 32'd5);
        @(posedge MemoryClk); #1;
        mif.mem_cmd_ready = 1'b1;
        wait_data(db + 16, "f5_wait");
        check_frame("f5", cb, db, 0, 16'h0201);
        check("f5_done", 32'(ndone), 32'd5);
        check("f5_active", 32'(active_frame), 32'd0);

        // marker mid-frame: error pulse, partial burst dropped, restart at buffer 1 origin
        nRST = 1'b0;
        tick(2);
        nRST = 1'b1;
        tick(2);
        cb = ncmd; db = ndata; done0 = ndone; err0 = nerr;
        push(17'h10000);
        for (int i = 0; i < 6; i++) push(17'h00501 + 17'(i));
        push_frame(16'h0601);
        t = 0;
        while (ncmd < cb + 4 && t < 500) begin
            @(negedge MemoryClk);
            t++;
        end
        check("err_cmds_seen", 32'(ncmd >= cb + 4), 32'd1);
        check("err_no_early_done", 32'(ndone), 32'(done0));
        wait_data(db + 20, "err_wait");
        check("err_pulses", 32'(nerr), 32'(err0 + 1));
        check("err_first_addr", cmd_log[cb], 32'd16);
        for (int i = 0; i < 4; i++)
            check($sformatf("err_first_data%0d", i), 32'(data_log[db+i]), 32'h0501 + 32'(i));
        check_frame("err_restart", cb + 1, db + 4, 16, 16'h0601);
        check("err_ncmd", 32'(ncmd), 32'(cb + 5));
        check("err_done", 32'(ndone), 32'(done0 + 1));
        check("err_active", 32'(active_frame), 32'd1);

        check("overpop", 32'(overpop), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
